// File: rtl/motion_pkg.sv
// Shared defaults and controller state encoding for the motion tracker.
//   W_DEF       : coordinate width per axis
//   N_DEF       : number of axes
//   HYST_DEF    : minimum |delta| that changes heading
//   STALL_N_DEF : consecutive still samples before stall asserts
//   state_t     : EMPTY (no previous sample) / PRIMED (previous sample held)
package motion_pkg;

    localparam int W_DEF       = 11;
    localparam int N_DEF       = 2;
    localparam int HYST_DEF    = 0;
    localparam int STALL_N_DEF = 8;

    typedef enum logic {
        EMPTY  = 1'b0,
        PRIMED = 1'b1
    } state_t;

endpackage

// File: rtl/motion_tracker_if.sv
// Sample/result bus of the motion tracker.
//   sample_en : pos holds a new sample (master -> slave)
//   pos       : packed positions, axis i at [i*W +: W]
//   heading   : per-axis direction, 1 = increasing
//   delta     : per-axis signed pos - previous pos, W+1 bits each
//   bounce    : per-axis one-cycle pulse on heading flip
//   stall     : per-axis level, axis not moving
//   valid     : delta/heading reflect at least two samples
interface motion_tracker_if
    import motion_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
);
    logic                 sample_en;
    logic [N*W-1:0]       pos;
    logic [N-1:0]         heading;
    logic [N*(W+1)-1:0]   delta;
    logic [N-1:0]         bounce;
    logic [N-1:0]         stall;
    logic                 valid;

    modport master (
        output sample_en, pos,
        input  heading, delta, bounce, stall, valid
    );

    modport slave (
        input  sample_en, pos,
        output heading, delta, bounce, stall, valid
    );
endinterface

// File: rtl/axis_tracker.sv
// Single-axis datapath: previous sample, delta, heading with hysteresis,
// bounce pulse and saturating stall counter.
//   clk, rst  : clock, asynchronous active-high reset
//   sample_en : pos is a new sample
//   primed    : a previous sample is held (controller in PRIMED)
//   pos       : current coordinate
//   delta     : registered signed pos - previous
//   heading   : registered direction
//   bounce    : one-cycle pulse when heading flips
//   stall     : high while the stall counter is saturated
module axis_tracker
    import motion_pkg::*;
#(
    parameter int   W         = W_DEF,
    parameter int   HYST      = HYST_DEF,
    parameter int   STALL_N   = STALL_N_DEF,
    parameter logic HEAD_INIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic                primed,
    input  logic [W-1:0]        pos,
    output logic signed [W:0]   delta,
    output logic                heading,
    output logic                bounce,
    output logic                stall
);
    localparam int             CW        = $clog2(STALL_N + 1);
    localparam logic [W:0]     HYST_V    = (W+1)'(HYST);
    localparam logic [CW-1:0]  STALL_MAX = CW'(STALL_N);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c == STALL_MAX)
            return c;
        return c + 1'b1;
    endfunction

    logic [W-1:0]        prev_p1;
    logic signed [W:0]   delta_p1;
    logic                heading_p1;
    logic                bounce_p1;
    logic [CW-1:0]       stall_cnt_p1;

    logic signed [W:0]   d_p0;
    logic [W:0]          mag_p0;
    logic                move_p0;
    logic                head_nxt_p0;

    // Stage p0: combinational difference; zero-extension to W+1 bits keeps
    // the full +/-(2^W-1) range without overflow.
    always_comb begin
        d_p0        = $signed({1'b0, pos}) - $signed({1'b0, prev_p1});
        mag_p0      = d_p0[W] ? $unsigned(-d_p0) : $unsigned(d_p0);
        move_p0     = mag_p0 > HYST_V;
        head_nxt_p0 = move_p0 ? ~d_p0[W] : heading_p1;
    end

    // Stage p1: registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_p1      <= '0;
            delta_p1     <= '0;
            heading_p1   <= HEAD_INIT;
            bounce_p1    <= 1'b0;
            stall_cnt_p1 <= '0;
        end else begin
            bounce_p1 <= 1'b0;
            if (sample_en) begin
                prev_p1 <= pos;
                if (primed) begin
                    delta_p1     <= d_p0;
                    heading_p1   <= head_nxt_p0;
                    bounce_p1    <= head_nxt_p0 != heading_p1;
                    stall_cnt_p1 <= move_p0 ? '0 : sat_inc(stall_cnt_p1);
                end
            end
        end
    end

    assign delta   = delta_p1;
    assign heading = heading_p1;
    assign bounce  = bounce_p1;
    assign stall   = stall_cnt_p1 == STALL_MAX;
endmodule

// File: rtl/motion_tracker.sv
// Multi-axis motion tracker: EMPTY/PRIMED controller, valid flag and N
// independent axis_tracker datapaths.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : motion_tracker_if.slave (sample_en, pos in; heading, delta,
//         bounce, stall, valid out)
module motion_tracker
    import motion_pkg::*;
#(
    parameter int         W         = W_DEF,
    parameter int         N         = N_DEF,
    parameter int         HYST      = HYST_DEF,
    parameter int         STALL_N   = STALL_N_DEF,
    parameter logic [N-1:0] HEAD_INIT = '1
) (
    input  logic            clk,
    input  logic            rst,
    motion_tracker_if.slave bus
);
    state_t               state, state_nxt;
    logic                 primed;
    logic                 valid_p1;
    logic [N-1:0]         heading_w;
    logic [N-1:0]         bounce_w;
    logic [N-1:0]         stall_w;
    logic [N*(W+1)-1:0]   delta_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (bus.sample_en) state_nxt = PRIMED;
            PRIMED:  state_nxt = PRIMED;
            default: state_nxt = EMPTY;
        endcase
    end

    assign primed = (state == PRIMED);

    // Stage p1: valid latches at the first sample taken while primed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_p1 <= 1'b0;
        else if (bus.sample_en && primed)
            valid_p1 <= 1'b1;
    end

    for (genvar i = 0; i < N; i++) begin : g_axis
        axis_tracker #(
            .W         (W),
            .HYST      (HYST),
            .STALL_N   (STALL_N),
            .HEAD_INIT (HEAD_INIT[i])
        ) u_axis (
            .clk       (clk),
            .rst       (rst),
            .sample_en (bus.sample_en),
            .primed    (primed),
            .pos       (bus.pos[i*W +: W]),
            .delta     (delta_w[i*(W+1) +: W+1]),
            .heading   (heading_w[i]),
            .bounce    (bounce_w[i]),
            .stall     (stall_w[i])
        );
    end

    assign bus.heading = heading_w;
    assign bus.delta   = delta_w;
    assign bus.bounce  = bounce_w;
    assign bus.stall   = stall_w;
    assign bus.valid   = valid_p1;
endmodule

// File: tb/tb_motion_tracker.sv
module tb_motion_tracker;
    localparam int W = 11;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    motion_tracker_if #(.W(W), .N(N)) bus_a ();
    motion_tracker_if #(.W(W), .N(N)) bus_b ();

    motion_tracker #(.W(W), .N(N), .HYST(0), .STALL_N(8), .HEAD_INIT(2'b11)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    motion_tracker #(.W(W), .N(N), .HYST(2), .STALL_N(3), .HEAD_INIT(2'b11)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic smp_a(input logic [W-1:0] x, input logic [W-1:0] y);
        bus_a.pos       = {y, x};
        bus_a.sample_en = 1'b1;
        @(posedge clk);
        #1;
        bus_a.sample_en = 1'b0;
    endtask

    task automatic smp_b(input logic [W-1:0] x, input logic [W-1:0] y);
        bus_b.pos       = {y, x};
        bus_b.sample_en = 1'b1;
        @(posedge clk);
        #1;
        bus_b.sample_en = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        chk("rst_valid_a", bus_a.valid, 0);
        chk("rst_head_a", bus_a.heading, 2'b11);
        chk("rst_delta_a", bus_a.delta, 0);
        chk("rst_stall_b", bus_b.stall, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.sample_en = 1'b0;
        bus_a.pos       = '0;
        bus_b.sample_en = 1'b0;
        bus_b.pos       = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", bus_a.valid, 0);
        chk("reset_heading", bus_a.heading, 2'b11);
        chk("reset_delta", bus_a.delta, 0);
        chk("reset_bounce", bus_a.bounce, 0);
        chk("reset_stall", bus_a.stall, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // first sample only primes
        smp_a(11'd60, 11'd500);
        chk("prime_valid", bus_a.valid, 0);
        chk("prime_delta", bus_a.delta, 0);
        chk("prime_heading", bus_a.heading, 2'b11);

        // 60 -> 63
        smp_a(11'd63, 11'd500);
        chk("inc_delta_x", bus_a.delta[11:0], 12'h003);
        chk("inc_delta_y", bus_a.delta[23:12], 12'h000);
        chk("inc_heading", bus_a.heading, 2'b11);
        chk("inc_valid", bus_a.valid, 1);
        chk("inc_bounce", bus_a.bounce, 0);

        // 63 -> 61 flips x
        smp_a(11'd61, 11'd500);
        chk("dec_delta_x", bus_a.delta[11:0], 12'hFFE);
        chk("dec_heading", bus_a.heading, 2'b10);
        chk("dec_bounce", bus_a.bounce, 2'b01);
        @(posedge clk);
        #1;
        chk("dec_bounce_gone", bus_a.bounce, 0);
        chk("hold_delta_x", bus_a.delta[11:0], 12'hFFE);

        // extremes, both axes flip together
        smp_a(11'd0, 11'd500);
        chk("to0_delta_x", bus_a.delta[11:0], 12'hFC3);
        chk("to0_bounce", bus_a.bounce, 0);
        smp_a(11'd2047, 11'd400);
        chk("max_delta_x", bus_a.delta[11:0], 12'h7FF);
        chk("max_delta_y", bus_a.delta[23:12], 12'hF9C);
        chk("max_heading", bus_a.heading, 2'b01);
        chk("max_bounce", bus_a.bounce, 2'b11);
        smp_a(11'd0, 11'd400);
        chk("min_delta_x", bus_a.delta[11:0], 12'h801);
        chk("min_heading", bus_a.heading, 2'b00);
        chk("min_bounce", bus_a.bounce, 2'b01);

        // idle cycles hold state
        repeat (3) @(posedge clk);
        #1;
        chk("idle_delta", bus_a.delta, {12'h000, 12'h801});
        chk("idle_bounce", bus_a.bounce, 0);
        chk("idle_stall", bus_a.stall, 0);

        // mid-operation reset discards the stored sample
        pulse_rst();
        smp_a(11'd5, 11'd5);
        chk("rprime_valid", bus_a.valid, 0);
        chk("rprime_delta", bus_a.delta, 0);
        chk("rprime_heading", bus_a.heading, 2'b11);
        chk("rprime_bounce", bus_a.bounce, 0);
        smp_a(11'd9, 11'd5);
        chk("rnext_delta_x", bus_a.delta[11:0], 12'h004);
        chk("rnext_valid", bus_a.valid, 1);

        // hysteresis, HYST=2, STALL_N=3
        smp_b(11'd100, 11'd0);
        smp_b(11'd102, 11'd0);
        chk("hyst_p2_heading", bus_b.heading, 2'b11);
        chk("hyst_p2_bounce", bus_b.bounce, 0);
        chk("hyst_p2_stall", bus_b.stall, 0);
        smp_b(11'd101, 11'd0);
        chk("hyst_m1_delta_x", bus_b.delta[11:0], 12'hFFF);
        chk("hyst_m1_heading", bus_b.heading, 2'b11);
        chk("hyst_m1_bounce", bus_b.bounce, 0);
        chk("hyst_m1_stall", bus_b.stall, 0);
        smp_b(11'd101, 11'd0);
        chk("hyst_sat_stall", bus_b.stall, 2'b11);
        smp_b(11'd106, 11'd0);
        chk("hyst_move_stall", bus_b.stall, 2'b10);
        chk("hyst_move_heading", bus_b.heading, 2'b11);

        // four equal samples after reset, then a move of +5
        pulse_rst();
        smp_b(11'd50, 11'd7);
        smp_b(11'd50, 11'd7);
        smp_b(11'd50, 11'd7);
        chk("stall_3rd", bus_b.stall, 0);
        smp_b(11'd50, 11'd7);
        chk("stall_4th", bus_b.stall, 2'b11);
        smp_b(11'd50, 11'd7);
        chk("stall_5th_sat", bus_b.stall, 2'b11);
        smp_b(11'd55, 11'd7);
        chk("stall_clear", bus_b.stall, 2'b10);
        chk("stall_clear_delta", bus_b.delta[11:0], 12'h005);
        smp_b(11'd53, 11'd7);
        chk("negedge_hyst_heading", bus_b.heading, 2'b11);
        chk("negedge_hyst_bounce", bus_b.bounce, 0);
        smp_b(11'd50, 11'd7);
        chk("neg_flip_heading", bus_b.heading, 2'b10);
        chk("neg_flip_bounce", bus_b.bounce, 2'b01);
        chk("neg_flip_stall", bus_b.stall, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/motion_tracker.md
MOTION_TRACKER -- requirements
Module: motion_tracker

Interface
REQ-001 Parameter W, default 11: coordinate width per axis, unsigned.
REQ-002 Parameter N, default 2: number of axes (channels).
REQ-003 Parameter HYST, default 0: minimum |delta| that changes heading, 0..2^W-1.
REQ-004 Parameter STALL_N, default 8: consecutive non-moving samples before stall asserts, >=1.
REQ-005 Parameter HEAD_INIT, default all-ones N bits: heading value after reset.
REQ-006 Port clk, input, 1: the single clock, rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port sample_en, input, 1: current pos is a new sample.
REQ-009 Port pos, input, N*W: packed positions, axis i at bits [i*W +: W].
REQ-010 Port heading, output, N: per-axis direction, 1 = increasing, 0 = decreasing.
REQ-011 Port delta, output, N*(W+1): per-axis signed two's-complement pos - previous pos.
REQ-012 Port bounce, output, N: one-cycle pulse per axis when its heading flips.
REQ-013 Port stall, output, N: per-axis level, axis not moving.
REQ-014 Port valid, output, 1: delta/heading reflect at least two samples.

Function
REQ-015 The block SHALL keep a two-state controller: EMPTY (no previous sample), PRIMED (previous sample held).
REQ-016 In EMPTY, sample_en SHALL store pos as previous, move to PRIMED, and leave heading, delta, bounce, stall unchanged.
REQ-017 In PRIMED, on sample_en each axis SHALL compute d = {0,pos} - {0,prev} in W+1 bits, register it on delta, and store pos as previous.
REQ-018 Heading SHALL become 1 when d > HYST, 0 when d < -HYST, and hold otherwise (d = 0 always holds).
REQ-019 bounce[i] SHALL pulse high for exactly the cycle after the sample edge at which heading[i] changes value; otherwise 0.
REQ-020 Per axis, a stall counter SHALL increment (saturating at STALL_N) on each PRIMED sample with |d| <= HYST and clear on any sample with |d| > HYST.
REQ-021 stall[i] SHALL be 1 exactly while its counter equals STALL_N.
REQ-022 valid SHALL go 1 at the first PRIMED sample edge and stay 1 until reset.
REQ-023 All outputs SHALL be registered; latency from sample_en edge to updated outputs is one clock.
REQ-024 Without sample_en, all state SHALL hold and bounce SHALL be 0.
REQ-025 Extremes (pos 0 -> 2^W-1 and back) SHALL give d = +(2^W-1) / -(2^W-1) without overflow.
REQ-026 Axes SHALL be fully independent; simultaneous bounces on several axes are allowed.

Reset
REQ-027 On rst: state EMPTY, heading = HEAD_INIT, delta = 0, bounce = 0, stall = 0, stall counters = 0, previous = 0, valid = 0.
REQ-028 Reset asserted mid-operation SHALL take effect immediately, discarding the stored sample; the first sample after release only primes.

Structure
REQ-029 Default values of W, N, HYST, STALL_N and the EMPTY/PRIMED state encoding SHALL reside in shared package motion_pkg.
REQ-030 Per-axis datapath (previous, delta, heading, bounce, stall counter) SHALL be sub-module axis_tracker, instantiated N times by generate; motion_tracker holds the controller and valid.

Verification
REQ-031 Reset, then samples x = 60, 63 -> after the second: delta = +3, heading[0] = 1, valid = 1, bounce = 0.
REQ-032 x samples 60, 63, 61 -> delta = -2, heading[0] = 0, bounce[0] high for one cycle.
REQ-033 HYST = 2, x samples 100, 102, 101 -> heading holds 1, no bounce; stall count advances.
REQ-034 STALL_N = 3, four equal samples -> stall = 1 after the 4th; next sample +5 -> stall = 0.
REQ-035 x samples 0, 2047 -> delta = +2047; y decreasing simultaneously -> both bounces in the same cycle.
REQ-036 rst pulsed between samples -> valid = 0, heading = HEAD_INIT; next sample changes no output but valid stays 0.
